axi4_mem_responder: RTL and testbench
=====================================

// Module: axi4_mem_responder
// PURPOSE
//  AXI4 memory slave answering the DCT DMA master port (m00_axi): accepts AR/AW bursts, serves R beats, absorbs W beats, issues B.
//  Backs a MEM_DEPTH x DATA_WIDTH array; simulation/emulation memory endpoint for the DMA + DCT datapath.
// PARAMETERS
//  ADDR_WIDTH  32    byte address width
//  DATA_WIDTH  256   beat width, bits (power of 2, >=32)
//  ID_WIDTH    1     AXI ID width
//  MEM_DEPTH   1024  words; power of 2
// PORTS
//  clk             in   1       clock
//  reset           in   1       sync, active-high
//  s_axi_awid      in   ID      write ID
//  s_axi_awvalid   in   1       AW valid
//  s_axi_awready   out  1       AW ready
//  s_axi_awaddr    in   ADDR    write byte address
//  s_axi_awlen     in   8       beats-1
//  s_axi_wvalid    in   1       W valid
//  s_axi_wready    out  1       W ready
//  s_axi_wdata     in   DATA    write data
//  s_axi_wstrb     in   DATA/8  byte enables
//  s_axi_wlast     in   1       last W beat
//  s_axi_bid       out  ID      = captured awid
//  s_axi_bvalid    out  1       B valid
//  s_axi_bready    in   1       B ready
//  s_axi_bresp     out  2       00 OKAY / 10 SLVERR
//  s_axi_arid      in   ID      read ID
//  s_axi_arvalid   in   1       AR valid
//  s_axi_arready   out  1       AR ready
//  s_axi_araddr    in   ADDR    read byte address
//  s_axi_arlen     in   8       beats-1
//  s_axi_rid       out  ID      = captured arid
//  s_axi_rvalid    out  1       R valid
//  s_axi_rready    in   1       R ready
//  s_axi_rdata     out  DATA    read data
//  s_axi_rresp     out  2       always 00
//  s_axi_rlast     out  1       last R beat
// BEHAVIOUR
//  Reset: all outputs 0, FSMs to IDLE, beat counters 0; memory contents retained. Reset mid-burst aborts the burst, no B/R issued.
//  Word index = (addr >> log2(DATA_WIDTH/8)) mod MEM_DEPTH, +1 per beat, wraps at MEM_DEPTH. Burst type/size ignored: INCR, full width.
//  Write FSM W_IDLE->W_DATA->W_RESP:
//   W_IDLE: awready=1; AW handshake latches id/idx/len, ->W_DATA.
//   W_DATA: wready=1; each handshake writes bytes where wstrb=1; beat n==len ->W_RESP.
//   wlast!=(n==len) on any beat sets err; burst length always from awlen.
//   W_RESP: bvalid=1, bresp=err?10:00; bready ->W_IDLE, err cleared. awready=0 outside W_IDLE.
//  Read FSM R_IDLE->R_FETCH->R_DATA:
//   R_IDLE: arready=1; AR handshake latches id/idx/len, ->R_FETCH.
//   R_FETCH: one cycle, rdata<=mem[idx]; ->R_DATA (first rvalid 2 cycles after AR handshake).
//   R_DATA: rvalid=1; rlast=(n==len); rdata/rvalid stable until rready.
//    Handshake with n<len reloads rdata from idx+1 same edge: full-rate beats under rready=1.
//    Handshake at n==len ->R_IDLE.
//  Channels independent, one outstanding burst each. Same-cycle read/write same word: read gets old data.
// CONFIGURATION
//  AXI_MEM_STALL_EN defined: free-running 3-bit counter; at count 7 wready=0 and no new R beat is presented.
//   rvalid already high stays high. Exercises master backpressure.
//  Not defined: no stall cycles; full-rate behaviour above.
// TESTING
//  Write awaddr=0x40 awlen=3, wdata=k, wstrb all 1 -> words 2..5=0..3, one B, bresp=00, bid=awid.
//  Read araddr=0x40 arlen=3, rready=1 -> rvalid 2 cycles after AR, 4 consecutive beats 0..3, rlast on 4th only.
//  wstrb=0x0000000F onto word of all 1s with wdata=0 -> low 4 bytes 0, rest unchanged.
//  awlen=1, wlast on beat 0 -> still 2 beats accepted, bresp=10; next burst bresp=00.
//  Read at word MEM_DEPTH-1, arlen=1 -> beats from words MEM_DEPTH-1 then 0; rready toggling -> rdata stable while stalled.
//  reset in W_DATA beat 2 -> no bvalid, awready=1 cycle after reset release; prior memory intact.

Source files
------------

// File: rtl/axi4_mem_responder.sv
// AXI4 memory slave backing a MEM_DEPTH x DATA_WIDTH array: independent write (AW/W/B) and read (AR/R) FSMs.
// Define AXI_MEM_STALL_EN to insert a periodic stall cycle on W acceptance and R beat presentation.
module axi4_mem_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 256,
  parameter int ID_WIDTH   = 1,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  output logic [1:0]              s_axi_bresp,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF    = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rstate_t;

  wstate_t wstate, wstate_nxt;
  rstate_t rstate, rstate_nxt;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [IDX_W-1:0] widx, ridx;
  logic [7:0]       wlen, wcnt, rlen, rcnt;
  logic             werr;
  logic             stall;
  logic             aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic             w_last_beat, r_last_beat;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^{s_axi_awaddr, s_axi_araddr};

`ifdef AXI_MEM_STALL_EN
  logic [2:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (reset) stall_cnt <= '0;
    else       stall_cnt <= stall_cnt + 3'd1;
  end

  assign stall = (stall_cnt == 3'd7);
`else
  assign stall = 1'b0;
`endif

  assign aw_hs       = s_axi_awvalid & s_axi_awready;
  assign w_hs        = s_axi_wvalid  & s_axi_wready;
  assign b_hs        = s_axi_bvalid  & s_axi_bready;
  assign ar_hs       = s_axi_arvalid & s_axi_arready;
  assign r_hs        = s_axi_rvalid  & s_axi_rready;
  assign w_last_beat = (wcnt == wlen);
  assign r_last_beat = (rcnt == rlen);

  // ---------------- write channel ----------------
  always_ff @(posedge clk) begin
    if (reset) wstate <= W_IDLE;
    else       wstate <= wstate_nxt;
  end

  always_comb begin
    wstate_nxt = wstate;
    case (wstate)
      W_IDLE:  if (aw_hs) wstate_nxt = W_DATA;
      W_DATA:  if (w_hs && w_last_beat) wstate_nxt = W_RESP;
      W_RESP:  if (s_axi_bready) wstate_nxt = W_IDLE;
      default: wstate_nxt = W_IDLE;
    endcase
  end

  // Readies are held low while reset is asserted so every output reads 0 in reset.
  always_comb begin
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    s_axi_bresp   = 2'b00;
    if (!reset) begin
      case (wstate)
        W_IDLE:  s_axi_awready = 1'b1;
        W_DATA:  s_axi_wready  = !stall;
        W_RESP: begin
          s_axi_bvalid = 1'b1;
          s_axi_bresp  = werr ? 2'b10 : 2'b00;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      widx      <= '0;
      wlen      <= '0;
      wcnt      <= '0;
      werr      <= 1'b0;
      s_axi_bid <= '0;
    end else begin
      if (aw_hs) begin
        s_axi_bid <= s_axi_awid;
        widx      <= s_axi_awaddr[OFF +: IDX_W];
        wlen      <= s_axi_awlen;
        wcnt      <= '0;
      end
      if (w_hs) begin
        widx <= widx + IDX_W'(1);
        wcnt <= wcnt + 8'd1;
        if (s_axi_wlast != w_last_beat) werr <= 1'b1;
      end
      if (b_hs) werr <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_hs) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (s_axi_wstrb[b]) mem[widx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  always_ff @(posedge clk) begin
    if (reset) rstate <= R_IDLE;
    else       rstate <= rstate_nxt;
  end

  // A stalled follow-on beat drops back to R_FETCH so rvalid deasserts until the stall clears.
  always_comb begin
    rstate_nxt = rstate;
    case (rstate)
      R_IDLE:  if (ar_hs) rstate_nxt = R_FETCH;
      R_FETCH: if (!stall) rstate_nxt = R_DATA;
      R_DATA: begin
        if (r_hs) begin
          if (r_last_beat) rstate_nxt = R_IDLE;
          else if (stall)  rstate_nxt = R_FETCH;
        end
      end
      default: rstate_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    s_axi_rlast   = 1'b0;
    s_axi_rresp   = 2'b00;
    if (!reset) begin
      case (rstate)
        R_IDLE:  s_axi_arready = 1'b1;
        R_DATA: begin
          s_axi_rvalid = 1'b1;
          s_axi_rlast  = r_last_beat;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ridx        <= '0;
      rlen        <= '0;
      rcnt        <= '0;
      s_axi_rid   <= '0;
      s_axi_rdata <= '0;
    end else begin
      if (ar_hs) begin
        s_axi_rid <= s_axi_arid;
        ridx      <= s_axi_araddr[OFF +: IDX_W];
        rlen      <= s_axi_arlen;
        rcnt      <= '0;
      end
      if (rstate == R_FETCH && !stall) s_axi_rdata <= mem[ridx];
      if (r_hs && !r_last_beat) begin
        ridx <= ridx + IDX_W'(1);
        rcnt <= rcnt + 8'd1;
        if (!stall) s_axi_rdata <= mem[ridx + IDX_W'(1)];
      end
    end
  end

endmodule

// File: tb/tb_axi4_mem_responder.sv
// Directed bench for axi4_mem_responder: reference memory model plus B/R scoreboard queues.
module tb_axi4_mem_responder;

  localparam int LIM = 64;

  logic         clk;
  logic         reset;
  logic [0:0]   s_axi_awid;
  logic         s_axi_awvalid;
  logic         s_axi_awready;
  logic [31:0]  s_axi_awaddr;
  logic [7:0]   s_axi_awlen;
  logic         s_axi_wvalid;
  logic         s_axi_wready;
  logic [255:0] s_axi_wdata;
  logic [31:0]  s_axi_wstrb;
  logic         s_axi_wlast;
  logic [0:0]   s_axi_bid;
  logic         s_axi_bvalid;
  logic         s_axi_bready;
  logic [1:0]   s_axi_bresp;
  logic [0:0]   s_axi_arid;
  logic         s_axi_arvalid;
  logic         s_axi_arready;
  logic [31:0]  s_axi_araddr;
  logic [7:0]   s_axi_arlen;
  logic [0:0]   s_axi_rid;
  logic         s_axi_rvalid;
  logic         s_axi_rready;
  logic [255:0] s_axi_rdata;
  logic [1:0]   s_axi_rresp;
  logic         s_axi_rlast;

  axi4_mem_responder #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(256),
    .ID_WIDTH(1),
    .MEM_DEPTH(1024)
  ) dut (
    .clk(clk), .reset(reset),
    .s_axi_awid(s_axi_awid), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_wdata(s_axi_wdata),
    .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_bid(s_axi_bid), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_bresp(s_axi_bresp),
    .s_axi_arid(s_axi_arid), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_rid(s_axi_rid), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast)
  );

  typedef struct packed {
    logic [255:0] data;
    logic         last;
  } rexp_t;

  typedef struct packed {
    logic [0:0] id;
    logic [1:0] resp;
  } bexp_t;

  rexp_t        rq[$];
  bexp_t        bq[$];
  logic [255:0] model [1024];
  int           errors = 0;
  int           checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "simulation time limit");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_aw(input logic [31:0] addr, input logic [7:0] len, input logic [0:0] id);
    int cyc = 0;
    s_axi_awvalid = 1'b1;
    s_axi_awaddr  = addr;
    s_axi_awlen   = len;
    s_axi_awid    = id;
    while (!s_axi_awready && cyc < LIM) begin
      @(negedge clk);
      cyc++;
    end
    chk("aw_wait", cyc < LIM, 1'b1);
    @(negedge clk);
    s_axi_awvalid = 1'b0;
  endtask

  task automatic do_ar(input logic [31:0] addr, input logic [7:0] len, input logic [0:0] id);
    int cyc = 0;
    s_axi_arvalid = 1'b1;
    s_axi_araddr  = addr;
    s_axi_arlen   = len;
    s_axi_arid    = id;
    while (!s_axi_arready && cyc < LIM) begin
      @(negedge clk);
      cyc++;
    end
    chk("ar_wait", cyc < LIM, 1'b1);
    @(negedge clk);
    s_axi_arvalid = 1'b0;
  endtask

  // stop_beat >= 0 asserts reset while that beat is offered and abandons the burst.
  task automatic write_burst(input logic [31:0] addr, input logic [7:0] len, input logic [0:0] id,
                             input logic [255:0] base, input logic [31:0] strb,
                             input bit early_last, input int stop_beat);
    int    cyc;
    bexp_t b;
    logic [9:0] idx;
    do_aw(addr, len, id);
    for (int k = 0; k <= int'(len); k++) begin
      s_axi_wvalid = 1'b1;
      s_axi_wdata  = base + 256'(k);
      s_axi_wstrb  = strb;
      s_axi_wlast  = early_last ? (k == 0) : (k == int'(len));
      if (k == stop_beat) begin
        reset = 1'b1;
        @(negedge clk);
        s_axi_wvalid = 1'b0;
        s_axi_wlast  = 1'b0;
        return;
      end
      cyc = 0;
      while (!s_axi_wready && cyc < LIM) begin
        @(negedge clk);
        cyc++;
      end
      chk("w_wait", cyc < LIM, 1'b1);
      idx = addr[14:5] + 10'(k);
      for (int unsigned j = 0; j < 32; j++)
        if (strb[j]) model[idx][8*j +: 8] = s_axi_wdata[8*j +: 8];
      @(negedge clk);
    end
    s_axi_wvalid = 1'b0;
    s_axi_wlast  = 1'b0;
    bq.push_back(bexp_t'{id: id, resp: (early_last && len != 8'd0) ? 2'b10 : 2'b00});
    cyc = 0;
    while (!s_axi_bvalid && cyc < LIM) begin
      @(negedge clk);
      cyc++;
    end
    chk("b_wait", cyc < LIM, 1'b1);
    if (bq.size() != 0) begin
      b = bq.pop_front();
      chk("bresp", s_axi_bresp, b.resp);
      chk("bid", s_axi_bid, b.id);
    end
    chk("awready_in_resp", s_axi_awready, 1'b0);
    s_axi_bready = 1'b1;
    @(negedge clk);
    s_axi_bready = 1'b0;
    chk("bvalid_after_b", s_axi_bvalid, 1'b0);
    chk("awready_after_b", s_axi_awready, 1'b1);
  endtask

  task automatic read_burst(input logic [31:0] addr, input logic [7:0] len, input logic [0:0] id,
                            input bit toggle);
    int           k = 0;
    int           cyc = 0;
    logic         rr;
    logic         stalled;
    logic [255:0] held;
    rexp_t        e;
    logic [9:0]   i0;
    i0 = addr[14:5];
    for (int j = 0; j <= int'(len); j++)
      rq.push_back(rexp_t'{data: model[i0 + 10'(j)], last: (j == int'(len))});
    do_ar(addr, len, id);
    chk("r_latency_fetch", s_axi_rvalid, 1'b0);
    @(negedge clk);
    chk("r_latency_valid", s_axi_rvalid, 1'b1);
    rr = !toggle;
    while (k <= int'(len) && cyc < LIM) begin
      s_axi_rready = rr;
      stalled = 1'b0;
      held = '0;
      if (s_axi_rvalid) begin
        if (rr) begin
          if (rq.size() != 0) begin
            e = rq.pop_front();
            chk("rdata", s_axi_rdata, e.data);
            chk("rlast", s_axi_rlast, e.last);
          end
          chk("rid", s_axi_rid, id);
          chk("rresp", s_axi_rresp, 2'b00);
          k++;
        end else begin
          held = s_axi_rdata;
          stalled = 1'b1;
        end
      end else if (!toggle && k > 0) begin
        chk("r_fullrate", s_axi_rvalid, 1'b1);
      end
      @(negedge clk);
      cyc++;
      if (stalled) begin
        chk("r_hold_valid", s_axi_rvalid, 1'b1);
        chk("r_hold_data", s_axi_rdata, held);
      end
      rr = toggle ? !rr : 1'b1;
    end
    s_axi_rready = 1'b0;
    chk("r_beats", k, int'(len) + 1);
    chk("r_idle_after", s_axi_rvalid, 1'b0);
    rq.delete();
  endtask

  initial begin
    reset = 1'b1;
    s_axi_awid = '0; s_axi_awvalid = 1'b0; s_axi_awaddr = '0; s_axi_awlen = '0;
    s_axi_wvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0;
    s_axi_bready = 1'b0;
    s_axi_arid = '0; s_axi_arvalid = 1'b0; s_axi_araddr = '0; s_axi_arlen = '0;
    s_axi_rready = 1'b0;
    repeat (3) @(negedge clk);

    // outputs during reset
    chk("rst_awready", s_axi_awready, 1'b0);
    chk("rst_wready", s_axi_wready, 1'b0);
    chk("rst_bvalid", s_axi_bvalid, 1'b0);
    chk("rst_bresp", s_axi_bresp, 2'b00);
    chk("rst_bid", s_axi_bid, 1'b0);
    chk("rst_arready", s_axi_arready, 1'b0);
    chk("rst_rvalid", s_axi_rvalid, 1'b0);
    chk("rst_rlast", s_axi_rlast, 1'b0);
    chk("rst_rdata", s_axi_rdata, 256'd0);
    chk("rst_rid", s_axi_rid, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_awready", s_axi_awready, 1'b1);
    chk("post_rst_arready", s_axi_arready, 1'b1);

    // basic burst: words 2..5 <= 0..3
    write_burst(32'h40, 8'd3, 1'b1, 256'd0, '1, 1'b0, -1);
    read_burst(32'h40, 8'd3, 1'b1, 1'b0);

    // byte strobes on an all-ones word
    write_burst(32'h140, 8'd0, 1'b0, '1, '1, 1'b0, -1);
    write_burst(32'h140, 8'd0, 1'b0, 256'd0, 32'h0000000F, 1'b0, -1);
    read_burst(32'h140, 8'd0, 1'b0, 1'b0);
    chk("strb_model", model[10], {{224{1'b1}}, 32'h0});

    // early wlast: two beats still accepted, SLVERR, then clean burst OKAY
    write_burst(32'h200, 8'd1, 1'b1, 256'h1234_0000, '1, 1'b1, -1);
    write_burst(32'h240, 8'd1, 1'b0, 256'h5678_0000, '1, 1'b0, -1);
    read_burst(32'h200, 8'd3, 1'b0, 1'b0);

    // wrap from last word to word 0, with rready toggling
    write_burst(32'h7FE0, 8'd1, 1'b0, 256'hABCD_0000, '1, 1'b0, -1);
    read_burst(32'h7FE0, 8'd1, 1'b1, 1'b1);
    // address beyond the array aliases modulo depth
    read_burst(32'h8040, 8'd1, 1'b0, 1'b1);

    // reset during beat 2 of a write burst
    write_burst(32'h280, 8'd3, 1'b0, 256'h1111_0000, '1, 1'b0, -1);
    write_burst(32'h280, 8'd3, 1'b1, 256'h2222_0000, '1, 1'b0, 2);
    chk("midrst_bvalid", s_axi_bvalid, 1'b0);
    chk("midrst_awready", s_axi_awready, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_awready_after", s_axi_awready, 1'b1);
    chk("midrst_wready_after", s_axi_wready, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("midrst_no_b", s_axi_bvalid, 1'b0);
    end
    read_burst(32'h280, 8'd3, 1'b0, 1'b0);
    read_burst(32'h40, 8'd3, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
